// File: rtl/inst_sramlike_bridge_pkg.sv
// Shared constants for the SRAM-like bus bridges: transfer size codes,
// the instruction-side bridge state encoding and a small alignment helper.
// The data-side bridge imports the same package for its size codes.
package inst_sramlike_bridge_pkg;

  // SRAM-like bus transfer size codes
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Defaults for the instruction bridge parameters
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
  localparam logic [1:0]  DEFAULT_INST_SIZE = SZ_WORD;

  // Instruction bridge states
  typedef enum logic [1:0] {
    IFB_REQ  = 2'b00,  // no transaction outstanding
    IFB_WAIT = 2'b01,  // address accepted, data outstanding
    IFB_DONE = 2'b10   // instruction buffered until the pipeline advances
  } ifb_state_e;

  // A fetch address is legal only on a 4-byte boundary
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/inst_sramlike_bridge.sv
// Instruction-side adapter between the CPU fetch stage and a split-transaction
// SRAM-like bus (req/addr_ok/data_ok). One fetch is in flight at a time; the
// fetched word is held while the pipeline stalls, and a response belonging to
// a fetch that was flushed by an exception/eret is dropped on arrival.
module inst_sramlike_bridge
  import inst_sramlike_bridge_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR,
  parameter logic [1:0]  INST_SIZE = DEFAULT_INST_SIZE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic        if_en,
  input  logic        longest_stall,
  input  logic        flush,
  output logic [31:0] if_instr,
  output logic        stallreq_from_if,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok
);

  ifb_state_e  state;
  logic        discard;    // outstanding response belongs to a flushed fetch
  logic [31:0] instr_buf;
  logic        fetch_go;
  logic        aligned;

  assign fetch_go = if_en & ~flush;
  assign aligned  = is_word_aligned(if_pc);

  // Read-only bus: address follows the fetch pc, which the datapath holds
  // stable while we stall, so req/addr stay put until addr_ok.
  assign inst_wr    = 1'b0;
  assign inst_size  = INST_SIZE;
  assign inst_wdata = 32'h0000_0000;
  assign inst_addr  = if_pc;

  // NOTE: inst_req and stallreq must react to if_pc/flush within the same
  // cycle, so they are decoded from the registered state rather than being
  // registered themselves; a registered request would arrive a cycle late.
  assign inst_req         = ~rst & (state == IFB_REQ) & fetch_go & aligned;
  assign stallreq_from_if = if_en & ~rst & (state != IFB_DONE) & ~flush;
  assign if_instr         = (state == IFB_DONE) ? instr_buf : NOP_INSTR;

  // Fetch sequencer: request, wait for data (or drop it), hold for the pipeline
  always_ff @(posedge clk) begin
    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // blocking assignments would let later statements see this cycle's update.
    if (rst) begin
      state     <= IFB_REQ;
      discard   <= 1'b0;
      instr_buf <= NOP_INSTR;
    end else begin
      case (state)
        IFB_REQ: begin
          if (fetch_go) begin
            if (!aligned) begin
              // AdEL is raised by the IF stage; present a bubble, touch no bus
              state     <= IFB_DONE;
              instr_buf <= NOP_INSTR;
            end else if (inst_addr_ok) begin
              state <= IFB_WAIT;
            end
          end
        end

        IFB_WAIT: begin
          if (inst_data_ok) begin
            discard <= 1'b0;
            if (discard || flush) begin
              // response is for a fetch the redirect has made obsolete
              state <= IFB_REQ;
            end else begin
              instr_buf <= inst_rdata;
              state     <= IFB_DONE;
            end
          end else if (flush) begin
            discard <= 1'b1;
          end
        end

        IFB_DONE: begin
          if (flush) begin
            state     <= IFB_REQ;
            instr_buf <= NOP_INSTR;
          end else if (!longest_stall) begin
            // pipeline latches if_instr this cycle
            state <= IFB_REQ;
          end
        end

        // NOTE: the unused 2-bit encoding recovers to the idle state instead
        // of being left unspecified.
        default: state <= IFB_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_sramlike_bridge.sv
// Self-checking bench for inst_sramlike_bridge: directed scenarios with
// hand-derived expectations, then randomized traffic checked against a
// transaction-level model of the fetch/hold/discard rules.
module tb_inst_sramlike_bridge;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_en;
  logic        longest_stall;
  logic        flush;
  logic [31:0] if_instr;
  logic        stallreq_from_if;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;

  int checks   = 0;
  int failures = 0;

  inst_sramlike_bridge dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .if_en            (if_en),
    .longest_stall    (longest_stall),
    .flush            (flush),
    .if_instr         (if_instr),
    .stallreq_from_if (stallreq_from_if),
    .inst_req         (inst_req),
    .inst_wr          (inst_wr),
    .inst_size        (inst_size),
    .inst_addr        (inst_addr),
    .inst_wdata       (inst_wdata),
    .inst_addr_ok     (inst_addr_ok),
    .inst_rdata       (inst_rdata),
    .inst_data_ok     (inst_data_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs are sampled on
  // the falling edge, then the bench advances past the next rising edge.
  task automatic cyc(input string tag, input logic e_req, input logic e_stall,
                     input logic [31:0] e_instr);
    #4;
    check({tag, ".req"},   {31'b0, inst_req},         {31'b0, e_req});
    check({tag, ".stall"}, {31'b0, stallreq_from_if}, {31'b0, e_stall});
    check({tag, ".instr"}, if_instr,                  e_instr);
    check({tag, ".addr"},  inst_addr,                 if_pc);
    check({tag, ".ctl"},   {29'b0, inst_wr, inst_size}, 32'h0000_0002);
    check({tag, ".wdata"}, inst_wdata,                32'h0000_0000);
    @(posedge clk);
    #1;
  endtask

  // Memory contents seen by the random bus: a fixed scramble of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = 32'hBFC0_0000 | ($urandom_range(0, 1023) << 2);
    if ($urandom_range(0, 7) == 0) p[1:0] = 2'($urandom_range(1, 3));
    return p;
  endfunction

  // Reference model: is a bus read in flight, does it belong to a flushed
  // fetch, and is a word being held for the pipeline.
  bit          m_busy, m_orphan, m_have;
  logic [31:0] m_word, m_acc_addr;
  int          bus_cnt;
  bit          prev_stall, prev_flush;
  logic        e_req, e_stall;
  logic [31:0] e_instr;

  initial begin
    rst = 1'b1; if_en = 1'b0; if_pc = 32'hBFC0_0000; longest_stall = 1'b0;
    flush = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    @(posedge clk);
    #1;

    // Reset: no request, no stall, NOP out, even with if_en high
    cyc("rst0", 1'b0, 1'b0, NOP);
    if_en = 1'b1;
    cyc("rst1", 1'b0, 1'b0, NOP);

    // 1. Basic fetch: addr_ok in request cycle, data_ok the next
    rst = 1'b0; if_pc = 32'hBFC0_0000; inst_addr_ok = 1'b1;
    cyc("t1.c0", 1'b1, 1'b1, NOP);
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3C08_BFC0;
    cyc("t1.c1", 1'b0, 1'b1, NOP);
    inst_data_ok = 1'b0; inst_rdata = 32'h0;
    cyc("t1.c2", 1'b0, 1'b0, 32'h3C08_BFC0);

    // 2. Slow bus: addr_ok after 3 cycles, data_ok 4 cycles after that
    if_pc = 32'hBFC0_0004;
    for (int i = 0; i < 3; i++) cyc("t2.req", 1'b1, 1'b1, NOP);
    inst_addr_ok = 1'b1;
    cyc("t2.acc", 1'b1, 1'b1, NOP);
    inst_addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) cyc("t2.wait", 1'b0, 1'b1, NOP);
    inst_data_ok = 1'b1; inst_rdata = 32'h2402_0001;
    cyc("t2.data", 1'b0, 1'b1, NOP);

    // 3. Held by pipeline stall for 5 cycles, then released
    inst_data_ok = 1'b0; inst_rdata = 32'h0; longest_stall = 1'b1;
    for (int i = 0; i < 5; i++) cyc("t3.hold", 1'b0, 1'b0, 32'h2402_0001);
    longest_stall = 1'b0;
    cyc("t3.rel", 1'b0, 1'b0, 32'h2402_0001);

    // 4. Flush while waiting: the orphaned response must never surface
    if_pc = 32'hBFC0_0008; inst_addr_ok = 1'b1;
    cyc("t4.acc", 1'b1, 1'b1, NOP);
    inst_addr_ok = 1'b0; flush = 1'b1;
    cyc("t4.flush", 1'b0, 1'b0, NOP);
    flush = 1'b0; if_pc = 32'hBFC0_0380;
    cyc("t4.orph", 1'b0, 1'b1, NOP);
    inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
    cyc("t4.drop", 1'b0, 1'b1, NOP);
    inst_data_ok = 1'b0; inst_addr_ok = 1'b1;
    cyc("t4.newreq", 1'b1, 1'b1, NOP);
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h4080_6000;
    cyc("t4.data", 1'b0, 1'b1, NOP);
    inst_data_ok = 1'b0;
    cyc("t4.deliv", 1'b0, 1'b0, 32'h4080_6000);

    // Flush coincident with data_ok: dropped, back to requesting
    if_pc = 32'hBFC0_0384; inst_addr_ok = 1'b1;
    cyc("t4b.acc", 1'b1, 1'b1, NOP);
    inst_addr_ok = 1'b0; flush = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'h1111_1111;
    cyc("t4b.both", 1'b0, 1'b0, NOP);
    flush = 1'b0; inst_data_ok = 1'b0; if_pc = 32'hBFC0_0390;
    cyc("t4b.req", 1'b1, 1'b1, NOP);

    // 5. Misaligned pc: no request, bubble in DONE; unsolicited data ignored
    if_pc = 32'hBFC0_0002;
    cyc("t5.mis", 1'b0, 1'b1, NOP);
    longest_stall = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hABCD_1234;
    cyc("t5.done", 1'b0, 1'b0, NOP);
    inst_data_ok = 1'b0; flush = 1'b1;
    cyc("t5.flush", 1'b0, 1'b0, NOP);
    flush = 1'b0; longest_stall = 1'b0; if_pc = 32'hBFC0_0010;
    cyc("t5.req", 1'b1, 1'b1, NOP);
    if_en = 1'b0;
    cyc("t5.idle", 1'b0, 1'b0, NOP);

    // 6. Reset while waiting, then a clean fetch
    if_en = 1'b1; if_pc = 32'hBFC0_0400; inst_addr_ok = 1'b1;
    cyc("t6.acc", 1'b1, 1'b1, NOP);
    rst = 1'b1; inst_addr_ok = 1'b0;
    cyc("t6.rst", 1'b0, 1'b0, NOP);
    rst = 1'b0;
    cyc("t6.req", 1'b1, 1'b1, NOP);
    inst_addr_ok = 1'b1;
    cyc("t6.acc2", 1'b1, 1'b1, NOP);
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h8C02_0010;
    cyc("t6.data", 1'b0, 1'b1, NOP);
    inst_data_ok = 1'b0;
    cyc("t6.deliv", 1'b0, 1'b0, 32'h8C02_0010);

    // Randomized traffic against the reference model
    rst = 1'b1; if_en = 1'b0; flush = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    cyc("rnd.rst", 1'b0, 1'b0, NOP);
    rst = 1'b0;
    m_busy = 0; m_orphan = 0; m_have = 0; m_word = NOP; m_acc_addr = 32'h0;
    bus_cnt = 0; prev_stall = 0; prev_flush = 0;

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      // datapath holds pc while the fetch stalls; a flush redirects it
      if (prev_flush || (!prev_stall && $urandom_range(0, 1) == 1)) if_pc = rand_pc();
      if_en         = ($urandom_range(0, 9) != 0);
      flush         = ($urandom_range(0, 9) == 0);
      longest_stall = ($urandom_range(0, 2) == 0);
      inst_addr_ok  = 1'($urandom_range(0, 1));
      if (m_busy) begin
        inst_data_ok = (bus_cnt == 0);
        inst_rdata   = inst_data_ok ? mem_word(m_acc_addr) : $urandom();
      end else begin
        inst_data_ok = ($urandom_range(0, 15) == 0);  // stray response
        inst_rdata   = $urandom();
      end

      e_req   = !rst && if_en && !flush && !m_busy && !m_have && (if_pc[1:0] == 2'b00);
      e_stall = !rst && if_en && !m_have && !flush;
      e_instr = m_have ? m_word : NOP;
      cyc("rnd", e_req, e_stall, e_instr);

      if (rst) begin
        m_busy = 0; m_orphan = 0; m_have = 0; bus_cnt = 0;
      end else if (m_have) begin
        if (flush || !longest_stall) m_have = 0;
      end else if (m_busy) begin
        if (inst_data_ok) begin
          m_busy = 0;
          if (!m_orphan && !flush) begin
            m_have = 1;
            m_word = mem_word(m_acc_addr);
          end
          m_orphan = 0;
        end else begin
          if (flush) m_orphan = 1;
          bus_cnt--;
        end
      end else if (e_req && inst_addr_ok) begin
        m_busy     = 1;
        m_acc_addr = if_pc;
        bus_cnt    = $urandom_range(0, 3);
      end else if (if_en && !flush && if_pc[1:0] != 2'b00) begin
        m_have = 1;
        m_word = NOP;
      end
      prev_stall = e_stall;
      prev_flush = flush && !rst;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_sramlike_bridge.md
Name: inst_sramlike_bridge

Overview:
- Instruction-side bus adapter directly upstream of the CPU datapath.
- Consumes the datapath's fetch address (if_pc) and returns if_instr plus stallreq_from_if.
- Drives a split-transaction SRAM-like bus (req/addr_ok/data_ok) toward the cache/AXI bridge.
- Holds a fetched instruction while the pipeline is stalled and discards responses orphaned by an exception flush.

Parameters:
NOP_INSTR, 32'h0000_0000, value driven on if_instr when no valid instruction is buffered.
INST_SIZE, 2'b10, inst_size code for a 4-byte transfer.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
if_pc  in  32  fetch address from datapath
if_en  in  1  fetch enable (0 while the IF stage is idle or in reset)
longest_stall  in  1  global pipeline stall (OR of all stall requests, including stallreq_from_if)
flush  in  1  exception/eret redirect; if_pc becomes mem_newpc next cycle
if_instr  out  32  instruction for the IF->ID register
stallreq_from_if  out  1  fetch not yet complete
inst_req  out  1  bus request
inst_wr  out  1  constant 0
inst_size  out  2  INST_SIZE
inst_addr  out  32  equals if_pc
inst_wdata  out  32  constant 0
inst_addr_ok  in  1  request accepted
inst_rdata  in  32  read data
inst_data_ok  in  1  read data valid

Behaviour:
- Reset is synchronous and active-high on clk. While rst=1 and after it: state=REQ, discard=0, instr_buf=NOP_INSTR. inst_req=0 and stallreq_from_if=0 while rst=1.
- States:
  - REQ: no transaction outstanding.
  - WAIT: address accepted, data outstanding.
  - DONE: instruction buffered, waiting for the pipeline to advance.
- Address error: if_pc[1:0]!=0 is misaligned (the IF stage flags AdEL).
- REQ:
  - inst_req = if_en & ~flush & aligned.
  - inst_req & inst_addr_ok -> WAIT.
  - if_en & ~flush & misaligned -> DONE with instr_buf=NOP_INSTR; no bus request.
  - if_en=0 -> stay.
- WAIT:
  - inst_req=0.
  - inst_data_ok & ~discard -> capture instr_buf=inst_rdata, go to DONE.
  - inst_data_ok & discard -> clear discard, go to REQ.
  - flush while waiting (data_ok low) -> set discard, stay.
  - flush coincident with data_ok -> treat as a discard: return to REQ, do not capture.
- DONE:
  - flush -> REQ, instr_buf=NOP_INSTR.
  - ~longest_stall -> REQ; the pipeline latches if_instr this cycle.
  - longest_stall -> hold state and instr_buf.
- if_instr = instr_buf when state==DONE, else NOP_INSTR.
- stallreq_from_if = if_en & ~rst & (state!=DONE) & ~flush. A flush cycle never requests a stall.
- Latency: with addr_ok in the request cycle and data_ok one cycle later, stallreq is high for 2 cycles and the instruction is delivered in the 3rd cycle. Throughput is 1 instruction per 3 cycles minimum; no pipelining of requests.
- Bus rules:
  - At most one outstanding transaction.
  - inst_data_ok is never asserted in the same cycle as its inst_addr_ok.
  - inst_addr and inst_req are held stable until addr_ok, because the datapath holds if_pc while stallreq_from_if=1.
  - Unsolicited data_ok in REQ or DONE is ignored.
- Reset mid-transaction: state returns to REQ with no discard tracking. The bus side must be reset on the same rst.

Decomposition:
- Add to defines.vh:
  - state encodings (`IFB_REQ`, `IFB_WAIT`, `IFB_DONE`, 2 bits);
  - SRAM-like size codes (`SZ_BYTE`=2'b00, `SZ_HALF`=2'b01, `SZ_WORD`=2'b10).
- Single flat module; no sub-module. The data-side bridge will reuse the same constants.

Test Plan:
1. Basic fetch: if_en=1, if_pc=0xBFC00000, addr_ok at cycle 0, data_ok+rdata=0x3C08BFC0 at cycle 1. Expect inst_req=1 only at cycle 0, stallreq high cycles 0-1, if_instr=0x3C08BFC0 at cycle 2, stallreq=0.
2. Slow bus: addr_ok delayed 3 cycles, data_ok 4 cycles after that. Expect inst_req held 4 cycles with constant inst_addr, then stallreq continuously high until data_ok, then instruction delivered.
3. Held by pipeline: in DONE with instr 0x24020001, raise longest_stall for 5 cycles. Expect if_instr stable at 0x24020001 and no new inst_req. On release, return to REQ.
4. Flush in WAIT: flush at the cycle after addr_ok, data_ok 2 cycles later with rdata=0xDEADBEEF. Expect 0xDEADBEEF never on if_instr. The next request goes to the new if_pc=0xBFC00380 and delivers its data.
5. Misaligned pc: if_pc=0xBFC00002, if_en=1. Expect no inst_req, DONE next cycle, if_instr=0x00000000, stallreq low.
6. Reset mid-WAIT: assert rst for 1 cycle while waiting. Expect inst_req=0, stallreq=0 and if_instr=0 during reset, and a clean fetch afterwards.
